instruction_fetch: RTL

Instruction fetch stage of the SCC pipeline, directly upstream of instruction decode. It generates word addresses into a synchronous single-port instruction memory and buffers up to four fetched words. It presents the head word (`Instruction`) and the word behind it (`Instruction_next`) to decode for lookahead. It also resolves unconditional `B` early (prefetch redirect), accepts late redirects from execute, and stops fetching on `HALT`.

---
 rtl/instruction_fetch.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: drives a synchronous instruction memory and queues up to four
// words for decode, with early unconditional-B redirect, execute redirect and HALT stop.
module instruction_fetch #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              id_ready,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              instr_valid,
    output logic [31:0]       Instruction,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              next_valid,
    output logic [31:0]       Instruction_next,
    output logic              halted
);

    localparam int DEPTH = 4;

    typedef enum logic {
        S_FETCH,
        S_HALTED
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   fetch_pc_reg, fetch_pc_next;
    logic                inflight_reg, inflight_next;
    logic [ADDR_W-1:0]   inflight_pc_reg, inflight_pc_next;
    logic [1:0]          head_reg, head_next;
    logic [1:0]          tail_reg, tail_next;
    logic [2:0]          count_reg, count_next;

    logic [31:0]         buf_word [DEPTH];
    logic [ADDR_W-1:0]   buf_pc   [DEPTH];

    logic                active;
    logic [31:0]         head_word;
    logic [ADDR_W-1:0]   head_pc;
    logic [1:0]          second_idx;
    logic [2:0]          occupancy;
    logic                pop;
    logic                is_b;
    logic                is_halt;
    logic                redirect;
    logic                b_pop;
    logic                halt_pop;
    logic                squash;
    logic                push;
    logic [ADDR_W-1:0]   b_offset;

    assign active     = (state_reg == S_FETCH);
    assign head_word  = buf_word[head_reg];
    assign head_pc    = buf_pc[head_reg];
    assign second_idx = head_reg + 2'd1;
    assign occupancy  = count_reg + 3'(inflight_reg);

    assign instr_valid = (count_reg != 3'd0);
    assign next_valid  = (count_reg >= 3'd2);
    assign pop         = instr_valid && id_ready;

    assign is_b    = (head_word[31:25] == 7'b1100000);
    assign is_halt = (head_word[31:30] == 2'b11) && (head_word[28:25] == 4'b1000);

    // Execute redirect outranks anything decided from the head word this cycle.
    assign redirect = active && branch_taken;
    assign b_pop    = active && pop && is_b && !redirect;
    assign halt_pop = active && pop && is_halt && !redirect;
    assign squash   = redirect || b_pop || halt_pop;
    assign push     = inflight_reg && active && !squash;

    // B displacement is a signed 16-bit word offset, sized to the address width.
    generate
        if (ADDR_W <= 16) begin : g_off_trunc
            assign b_offset = head_word[ADDR_W-1:0];
        end else begin : g_off_sext
            assign b_offset = {{(ADDR_W-16){head_word[15]}}, head_word[15:0]};
        end
    endgenerate

    assign imem_en   = !rst && active && (occupancy < 3'd4) && !squash;
    assign imem_addr = fetch_pc_reg;

    assign Instruction      = instr_valid ? head_word : 32'd0;
    assign instr_pc         = instr_valid ? head_pc : '0;
    assign Instruction_next = next_valid ? buf_word[second_idx] : 32'd0;
    assign halted           = (state_reg == S_HALTED);

    always_comb begin
        state_next       = state_reg;
        fetch_pc_next    = fetch_pc_reg;
        inflight_next    = 1'b0;
        inflight_pc_next = inflight_pc_reg;
        head_next        = head_reg;
        tail_next        = tail_reg;
        count_next       = count_reg;

        if (imem_en) begin
            fetch_pc_next    = fetch_pc_reg + ADDR_W'(1);
            inflight_next    = 1'b1;
            inflight_pc_next = fetch_pc_reg;
        end

        if (redirect) begin
            fetch_pc_next = branch_target;
            head_next     = 2'd0;
            tail_next     = 2'd0;
            count_next    = 3'd0;
        end else if (b_pop) begin
            fetch_pc_next = head_pc + b_offset;
            head_next     = 2'd0;
            tail_next     = 2'd0;
            count_next    = 3'd0;
        end else if (halt_pop) begin
            state_next = S_HALTED;
            head_next  = 2'd0;
            tail_next  = 2'd0;
            count_next = 3'd0;
        end else begin
            head_next  = head_reg + 2'(pop);
            tail_next  = tail_reg + 2'(push);
            count_next = count_reg + 3'(push) - 3'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= S_FETCH;
            fetch_pc_reg    <= RESET_PC;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
            head_reg        <= 2'd0;
            tail_reg        <= 2'd0;
            count_reg       <= 3'd0;
        end else begin
            state_reg       <= state_next;
            fetch_pc_reg    <= fetch_pc_next;
            inflight_reg    <= inflight_next;
            inflight_pc_reg <= inflight_pc_next;
            head_reg        <= head_next;
            tail_reg        <= tail_next;
            count_reg       <= count_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [31:0]       word_reg;
            logic [ADDR_W-1:0] pc_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    word_reg <= '0;
                    pc_reg   <= '0;
                end else if (push && (tail_reg == 2'(gi))) begin
                    word_reg <= imem_rdata;
                    pc_reg   <= inflight_pc_reg;
                end
            end

            assign buf_word[gi] = word_reg;
            assign buf_pc[gi]   = pc_reg;
        end
    endgenerate

endmodule
